// File: rtl/button_repeat_pkg.sv
// Shared types for the button debouncer / auto-repeat block.
// The state encoding is also exported on state_dbg, so keep values stable.
package button_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RELEASED  = 3'd0,
    PRESS_DEB = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    REL_DEB   = 3'd4
  } state_t;

  // Debounced level is high from the confirmed press until the release is confirmed.
  function automatic logic is_pressed_state(input state_t s);
    return (s == HELD) || (s == REPEAT) || (s == REL_DEB);
  endfunction

endpackage

// File: rtl/button_repeat_synchronizer.sv
// Two-flop synchronizer for slow asynchronous levels (buttons, switches).
// RST_VAL lets active-low inputs reset to their idle level.
module synchronizer #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/button_repeat.sv
// Debounces one raw button and produces cursor-step pulses: one on a confirmed
// press, then auto-repeat after a hold delay. Sequenced by the external tick.
module button_repeat
  import button_pkg::*;
#(
  parameter int N              = 8,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 10,
  parameter int REPEAT_TICKS   = 3,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         tick,
  input  logic         button_in,
  output logic         pressed,
  output logic         step,
  output logic [2:0]   state_dbg
);

  localparam logic         IDLE_RAW = (ACTIVE_LOW != 0);
  localparam logic [N-1:0] DEB_LIM  = N'(DEBOUNCE_TICKS - 1);
  localparam logic [N-1:0] HOLD_LIM = N'(HOLD_TICKS - 1);
  localparam logic [N-1:0] REP_LIM  = N'(REPEAT_TICKS - 1);
  localparam logic [N-1:0] CNT_ONE  = N'(1);

  logic         w_btn_raw;
  logic         w_btn_s;

  state_t       r_state;
  logic [N-1:0] r_cnt;
  logic         r_step;

  state_t       w_state_nxt;
  logic [N-1:0] w_cnt_nxt;
  logic         w_step_nxt;

  // Free-running: must keep tracking the pin even while the FSM is frozen.
  synchronizer #(
    .RST_VAL (IDLE_RAW)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (button_in),
    .o_q   (w_btn_raw)
  );

  assign w_btn_s = w_btn_raw ^ IDLE_RAW;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_step  <= 1'b0;
    end else if (ena && tick) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_step  <= w_step_nxt;
    end else begin
      r_step  <= 1'b0;
    end
  end

  // Limits are compared with >= so a counter can never run past its limit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step_nxt  = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_btn_s) begin
          w_state_nxt = PRESS_DEB;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PRESS_DEB: begin
        if (!w_btn_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LIM) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = REL_DEB;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt >= HOLD_LIM) begin
          w_state_nxt = REPEAT;
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      REPEAT: begin
        if (!w_btn_s) begin
          w_state_nxt = REL_DEB;
          w_cnt_nxt   = CNT_ONE;
        end else if (r_cnt >= REP_LIM) begin
          w_cnt_nxt   = '0;
          w_step_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      REL_DEB: begin
        // A bounce during release restarts the hold delay without a step.
        if (w_btn_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= DEB_LIM) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    pressed   = is_pressed_state(r_state);
    state_dbg = r_state;
    step      = r_step;
  end

endmodule
